multi_tick_gen: RTL



---
 rtl/multi_tick_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/multi_tick_gen.sv
// Multi-channel tick generator: per-channel divisor with off/periodic/one-shot modes.
// Optional square-wave outputs (sq_o) when MULTI_TICK_GEN_SQUARE_EN is defined.
module multi_tick_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_CH-1:0] start,
  output logic [NUM_CH-1:0] tick_o,
`ifdef MULTI_TICK_GEN_SQUARE_EN
  output logic [NUM_CH-1:0] sq_o,
`endif
  output logic [NUM_CH-1:0] busy_o
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_PER  = 2'd1,
    MODE_ONE  = 2'd2,
    MODE_RSV  = 2'd3
  } mode_e;

  logic [CNT_W-1:0]  div_q   [NUM_CH];
  logic [CNT_W-1:0]  div_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  mode_e             mode_q  [NUM_CH];
  mode_e             mode_d  [NUM_CH];
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [NUM_CH-1:0] tick_q,  tick_d;
  logic [NUM_CH-1:0] busy_q,  busy_d;
`ifdef MULTI_TICK_GEN_SQUARE_EN
  logic [NUM_CH-1:0] sq_q,    sq_d;
`endif

  // Reload value max(d,1)-1, so a zero divisor behaves as one.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    tick_d  = '0;
    busy_d  = '0;
`ifdef MULTI_TICK_GEN_SQUARE_EN
    sq_d    = sq_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      // A config write outranks start, which outranks normal counting.
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        mode_d[i]  = mode_e'(cfg_mode);
        cnt_d[i]   = reload_val(cfg_div);
        armed_d[i] = 1'b0;
`ifdef MULTI_TICK_GEN_SQUARE_EN
        sq_d[i]    = 1'b0;
`endif
      end else if (start[i] && (mode_q[i] == MODE_PER)) begin
        cnt_d[i] = reload_val(div_q[i]);
      end else if (start[i] && (mode_q[i] == MODE_ONE)) begin
        cnt_d[i]   = reload_val(div_q[i]);
        armed_d[i] = 1'b1;
      end else if ((mode_q[i] == MODE_PER) || ((mode_q[i] == MODE_ONE) && armed_q[i])) begin
        if (cnt_q[i] == '0) begin
          tick_d[i] = 1'b1;
          cnt_d[i]  = reload_val(div_q[i]);
          if (mode_q[i] == MODE_ONE) begin
            armed_d[i] = 1'b0;
          end
`ifdef MULTI_TICK_GEN_SQUARE_EN
          sq_d[i] = ~sq_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
      busy_d[i] = (mode_d[i] == MODE_PER) || ((mode_d[i] == MODE_ONE) && armed_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= CNT_W'(DEFAULT_DIV);
        cnt_q[i]  <= CNT_W'(DEFAULT_DIV - 1);
        mode_q[i] <= MODE_PER;
      end
      armed_q <= '0;
      tick_q  <= '0;
      busy_q  <= '1;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MULTI_TICK_GEN_SQUARE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;
`endif

  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule
